// File: rtl/rtc_access_scheduler.sv
// Arbitrates host register writes and periodic RTC read sweeps onto a single-outstanding
// RTC bus engine. Define RTC_INIT_SEQ_EN to run a fixed init write sequence after reset.
module rtc_access_scheduler #(
    parameter int REFRESH_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       eng_start,
    output logic       eng_w_r,
    output logic [7:0] eng_addr,
    output logic [7:0] eng_wdata,
    input  logic       eng_done,
    input  logic [7:0] eng_rdata,
    output logic       rd_valid,
    output logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       err
);
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_INIT} state_t;

    state_t          state;
    logic [RW-1:0]   refresh_cnt;
    logic [TW-1:0]   wait_cnt;
    logic [3:0]      sweep_idx;
    logic            sweep_pending;
    logic            sweep_active;
    logic            refresh_tick;

    function automatic logic [7:0] sweep_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h21;
            4'd1:    return 8'h22;
            4'd2:    return 8'h23;
            4'd3:    return 8'h24;
            4'd4:    return 8'h25;
            4'd5:    return 8'h26;
            4'd6:    return 8'h27;
            4'd7:    return 8'h41;
            4'd8:    return 8'h42;
            default: return 8'h43;
        endcase
    endfunction

`ifdef RTC_INIT_SEQ_EN
    logic       init_mode;
    logic [1:0] init_step;

    function automatic logic [7:0] init_addr(input logic [1:0] step);
        case (step)
            2'd0:    return 8'h02;
            2'd1:    return 8'h02;
            2'd2:    return 8'h10;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] init_data(input logic [1:0] step);
        case (step)
            2'd0:    return 8'h10;
            2'd1:    return 8'h00;
            2'd2:    return 8'hD2;
            default: return 8'h00;
        endcase
    endfunction
`endif

    assign refresh_tick = (refresh_cnt == REFRESH_LAST);
    assign busy         = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef RTC_INIT_SEQ_EN
            state         <= S_INIT;
            init_mode     <= 1'b1;
            init_step     <= 2'd0;
`else
            state         <= S_IDLE;
`endif
            refresh_cnt   <= '0;
            wait_cnt      <= '0;
            sweep_idx     <= 4'd0;
            sweep_pending <= 1'b1;
            sweep_active  <= 1'b0;
            eng_start     <= 1'b0;
            eng_w_r       <= 1'b0;
            eng_addr      <= 8'h00;
            eng_wdata     <= 8'h00;
            wr_ack        <= 1'b0;
            rd_valid      <= 1'b0;
            rd_addr       <= 8'h00;
            rd_data       <= 8'h00;
            err           <= 1'b0;
        end else begin
            eng_start   <= 1'b0;
            wr_ack      <= 1'b0;
            rd_valid    <= 1'b0;
            err         <= 1'b0;
            refresh_cnt <= refresh_tick ? '0 : refresh_cnt + RW'(1);

            case (state)
`ifdef RTC_INIT_SEQ_EN
                S_INIT: begin
                    wait_cnt  <= '0;
                    eng_start <= 1'b1;
                    eng_w_r   <= 1'b1;
                    eng_addr  <= init_addr(init_step);
                    eng_wdata <= init_data(init_step);
                    state     <= S_ISSUE;
                end
`endif
                S_IDLE: begin
                    wait_cnt <= '0;
                    // The requester still sees wr_req high in the ack cycle; skip it so
                    // the just-acked write is not issued a second time.
                    if (wr_req && !wr_ack) begin
                        eng_start <= 1'b1;
                        eng_w_r   <= 1'b1;
                        eng_addr  <= wr_addr;
                        eng_wdata <= wr_data;
                        state     <= S_ISSUE;
                    end else if (sweep_pending || sweep_active) begin
                        eng_start    <= 1'b1;
                        eng_w_r      <= 1'b0;
                        eng_addr     <= sweep_addr(sweep_idx);
                        eng_wdata    <= 8'h00;
                        state        <= S_ISSUE;
                        sweep_active <= 1'b1;
                        // Consume the pending flag only when a new sweep begins, so a tick
                        // landing mid-sweep queues exactly one more sweep.
                        if (!sweep_active)
                            sweep_pending <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= wait_cnt + TW'(1);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        state <= S_IDLE;
`ifdef RTC_INIT_SEQ_EN
                        if (init_mode) begin
                            if (init_step == 2'd3)
                                init_mode <= 1'b0;
                            else begin
                                init_step <= init_step + 2'd1;
                                state     <= S_INIT;
                            end
                        end else
`endif
                        if (eng_w_r)
                            wr_ack <= 1'b1;
                        else begin
                            rd_valid <= 1'b1;
                            rd_addr  <= eng_addr;
                            rd_data  <= eng_rdata;
                            if (sweep_idx == 4'd9) begin
                                sweep_idx    <= 4'd0;
                                sweep_active <= 1'b0;
                            end else
                                sweep_idx <= sweep_idx + 4'd1;
                        end
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
`ifdef RTC_INIT_SEQ_EN
                        if (init_mode) begin
                            init_step <= 2'd0;
                            state     <= S_INIT;
                        end else
`endif
                        if (!eng_w_r) begin
                            sweep_idx     <= 4'd0;
                            sweep_active  <= 1'b0;
                            sweep_pending <= 1'b0;
                        end
                    end else
                        wait_cnt <= wait_cnt + TW'(1);
                end
                default: state <= S_IDLE;
            endcase

            if (refresh_tick)
                sweep_pending <= 1'b1;
        end
    end
endmodule

// File: doc/rtc_access_scheduler.md
RTC_ACCESS_SCHEDULER -- requirements
Module: rtc_access_scheduler

Interface
REQ-001 Parameter: REFRESH_CYCLES, default 1000000, clock cycles between periodic RTC read sweeps.
REQ-002 Parameter: TIMEOUT_CYCLES, default 4096, maximum cycles to wait for eng_done per transaction.
REQ-003 Port: clk  in  1  single system clock, all state on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: wr_req  in  1  write request level, held with wr_addr/wr_data stable until wr_ack.
REQ-006 Port: wr_addr  in  8  RTC register address to write.
REQ-007 Port: wr_data  in  8  byte to write.
REQ-008 Port: wr_ack  out  1  one-cycle pulse, write transaction completed.
REQ-009 Port: eng_start  out  1  one-cycle start pulse to the RTC bus pulse generator.
REQ-010 Port: eng_w_r  out  1  1 = write, 0 = read; valid from eng_start until eng_done.
REQ-011 Port: eng_addr  out  8  RTC address for current transaction, held until eng_done.
REQ-012 Port: eng_wdata  out  8  write byte, held until eng_done.
REQ-013 Port: eng_done  in  1  one-cycle completion pulse from the pulse generator.
REQ-014 Port: eng_rdata  in  8  byte captured from the bidirectional dato bus, valid with eng_done.
REQ-015 Port: rd_valid  out  1  one-cycle pulse, rd_addr/rd_data carry a fresh read result.
REQ-016 Port: rd_addr  out  8  address of the completed read.
REQ-017 Port: rd_data  out  8  byte read.
REQ-018 Port: busy  out  1  high in every state except IDLE.
REQ-019 Port: err  out  1  one-cycle pulse on transaction timeout.

Function
REQ-020 Sweep table, fixed, index 0..9: 0x21,0x22,0x23,0x24,0x25,0x26,0x27,0x41,0x42,0x43 (seg, min, hora, dia, mes, año, dia semana, seg/min/hora timer).
REQ-021 Refresh counter counts 0..REFRESH_CYCLES-1 continuously, wraps; at wrap sets sweep_pending (single flag, repeated ticks while pending are not counted).
REQ-022 States: IDLE, ISSUE, WAIT; plus INIT when configured (REQ-034).
REQ-023 IDLE arbitration, evaluated each cycle: wr_req high -> write; else sweep_pending or sweep in progress -> read at current sweep index; else stay.
REQ-024 Write priority applies between sweep items: a write arriving mid-sweep is served after the current read completes; the sweep then resumes at the next index.
REQ-025 ISSUE lasts exactly one cycle: eng_start=1 with eng_w_r/eng_addr/eng_wdata valid; next state WAIT; decision-to-eng_start latency 1 cycle from IDLE.
REQ-026 WAIT: on eng_done, read -> rd_valid=1, rd_addr=eng_addr, rd_data=eng_rdata same cycle as eng_done registered (one cycle after eng_done); write -> wr_ack=1 one cycle after eng_done; return to IDLE.
REQ-027 After index 9 read completes, index returns to 0 and sweep_pending clears; refresh tick during a sweep re-sets sweep_pending, giving one further sweep.
REQ-028 WAIT timeout: wait counter reaching TIMEOUT_CYCLES-1 without eng_done -> err pulse, no ack/valid, IDLE; a timed-out write stays requested (wr_req still high) and is retried; a timed-out read aborts the sweep (index 0, pending cleared).
REQ-029 eng_done outside WAIT is ignored.
REQ-030 wr_req deasserted before ack: transaction already issued completes; wr_ack still pulses.
REQ-031 Only one transaction outstanding; eng_start never asserts while in WAIT.

Reset
REQ-032 On reset assertion, immediately: state IDLE (or INIT), all pulses 0, eng_addr/eng_wdata/rd_addr/rd_data 0x00, eng_w_r 0, sweep index 0, refresh and wait counters 0, sweep_pending 1 (first sweep starts after reset release).
REQ-033 Reset mid-transaction abandons it; no ack, valid or err emitted.

Configuration
REQ-034 Macro RTC_INIT_SEQ_EN defined: after reset, INIT issues writes 0x02<-0x10, 0x02<-0x00, 0x10<-0xD2, 0x00<-0x00 in order via ISSUE/WAIT, no wr_ack; wr_req and sweeps deferred until done; timeout restarts the sequence from step 0. Undefined: reset goes directly to IDLE.

Verification
REQ-035 Reset release, REFRESH_CYCLES=64, eng_done 5 cycles after each eng_start -> ten reads, addresses 0x21..0x27,0x41..0x43, ten rd_valid pulses with echoed eng_rdata.
REQ-036 wr_req with 0x22/0x45 during read of 0x23 -> 0x23 completes, write 0x22 issued with eng_w_r=1, wr_ack once, sweep resumes at 0x24.
REQ-037 eng_done withheld, TIMEOUT_CYCLES=16 -> err pulse 16 cycles after eng_start, sweep aborted, index 0.
REQ-038 Reset asserted during WAIT -> outputs zero immediately, no rd_valid; sweep restarts at 0x21.
REQ-039 RTC_INIT_SEQ_EN defined -> four writes 0x02,0x02,0x10,0x00 with data 0x10,0x00,0xD2,0x00 precede first read of 0x21.
